fetch_queue: RTL

//  Instruction prefetch queue that sits directly upstream of StageOne decode.
//  It owns the fetch PC and issues word reads to instruction memory, one per cycle.

---
 rtl/fetch_queue.sv | 103 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues one imem read per cycle, buffers words for decode.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [DATA_W-1:0]      imem_rdata,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      instruction,
  output logic [ADDR_W-1:0]      pc_out,
  output logic [ADDR_W-1:0]      pc_1,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic              resp;
  logic              push;
  logic              pop;
  logic [CW:0]       credits;

  // Outstanding reads reserve a slot so a response always has room.
  assign credits   = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign imem_req  = !rst && !redirect && (credits < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign resp      = inflight && !redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic empty;
  logic bypass;
  assign empty       = (count == '0);
  assign bypass      = empty && resp;
  assign out_valid   = !empty || bypass;
  assign instruction = empty ? imem_rdata : data_q[head];
  assign pc_out      = empty ? inflight_pc : pc_q[head];
  assign push        = resp && !(bypass && out_ready);
  assign pop         = !empty && out_ready && !redirect;
`else
  assign out_valid   = (count != '0);
  assign instruction = data_q[head];
  assign pc_out      = pc_q[head];
  assign push        = resp;
  assign pop         = out_valid && out_ready && !redirect;
`endif

  assign pc_1 = pc_out + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else begin
      inflight    <= imem_req;
      inflight_pc <= fetch_pc;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        if (imem_req) fetch_pc <= fetch_pc + ADDR_W'(1);
        if (push)     tail     <= tail + PW'(1);
        if (pop)      head     <= head + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      data_q[tail] <= imem_rdata;
      pc_q[tail]   <= inflight_pc;
    end
  end

  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count == CW'(DEPTH)));

endmodule
